// File: rtl/i2s_pkg.sv
// Shared audio constants and helpers for the I2S transmitter.
// Mixer-to-DAC word conversion and slot bit selection.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int WORD_BITS  = 16;
  localparam int MIX_BITS   = 12;
  localparam int CNT_BITS   = $clog2(FRAME_BITS);

  // Unsigned mix to left-justified two's complement.
  function automatic logic [WORD_BITS-1:0] to_word(
    input logic [MIX_BITS-1:0] mix
  );
    return {~mix[MIX_BITS-1], mix[MIX_BITS-2:0], 4'b0000};
  endfunction

  // Bit driven at frame position cnt; one-bit delay after lrck edge.
  function automatic logic slot_bit(
    input logic [WORD_BITS-1:0] lw,
    input logic [WORD_BITS-1:0] rw,
    input logic [CNT_BITS-1:0]  cnt
  );
    logic [4:0]           k;
    logic [3:0]           idx;
    logic [WORD_BITS-1:0] w;
    k   = cnt[4:0];
    w   = cnt[5] ? rw : lw;
    idx = 4'(5'd16 - k);
    return (k != 5'd0 && k <= 5'd16) ? w[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/i2s.sv
// Philips I2S transmitter: 32 bit-clocks per slot, sck/lrck
// derived from the system clock, words latched once per frame.
module i2s
  import i2s_pkg::*;
#(
  parameter int DIV = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [MIX_BITS-1:0] laudio,
  input  logic [MIX_BITS-1:0] raudio,
  output logic                sck,
  output logic                lrck,
  output logic                sdata,
  output logic                sample
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0]        r_div;
  logic                 r_sck;
  logic [CNT_BITS-1:0]  r_cnt;
  logic                 r_lrck;
  logic                 r_sdata;
  logic                 r_sample;
  logic [WORD_BITS-1:0] r_lword;
  logic [WORD_BITS-1:0] r_rword;

  logic                 w_tick;
  logic                 w_fall;
  logic                 w_wrap;
  logic [CNT_BITS-1:0]  w_cnt_nxt;
  logic [WORD_BITS-1:0] w_lword_nxt;
  logic [WORD_BITS-1:0] w_rword_nxt;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_fall      = w_tick & r_sck;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_wrap      = w_fall && (r_cnt == CNT_BITS'(FRAME_BITS - 1));
  assign w_lword_nxt = w_wrap ? to_word(laudio) : r_lword;
  assign w_rword_nxt = w_wrap ? to_word(raudio) : r_rword;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_div    <= '0;
      r_sck    <= 1'b0;
      r_cnt    <= '0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
      r_sample <= 1'b0;
      r_lword  <= '0;
      r_rword  <= '0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      r_sample <= w_wrap;
      r_lword  <= w_lword_nxt;
      r_rword  <= w_rword_nxt;
      if (w_tick) r_sck <= ~r_sck;
      // Serial outputs move only on the sck falling edge.
      if (w_fall) begin
        r_cnt   <= w_cnt_nxt;
        r_lrck  <= w_cnt_nxt[5];
        r_sdata <= slot_bit(w_lword_nxt, w_rword_nxt, w_cnt_nxt);
      end
    end
  end

  assign sck    = r_sck;
  assign lrck   = r_lrck;
  assign sdata  = r_sdata;
  assign sample = r_sample;

endmodule

// File: tb/tb_i2s.sv
// Bench for i2s: frame-level reference model checked every clock,
// plus directed frame captures against hand-computed words.
module tb_i2s;

  logic        clock;
  logic        rst_a, rst_b;
  logic [11:0] laud_a, raud_a, laud_b, raud_b;
  logic        sck_a, lrck_a, sdata_a, sample_a;
  logic        sck_b, lrck_b, sdata_b, sample_b;

  int n_chk;
  int n_fail;

  i2s #(.DIV(2)) dut_a (
    .clock(clock), .reset(rst_a), .laudio(laud_a), .raudio(raud_a),
    .sck(sck_a), .lrck(lrck_a), .sdata(sdata_a), .sample(sample_a)
  );

  i2s #(.DIV(1)) dut_b (
    .clock(clock), .reset(rst_b), .laudio(laud_b), .raudio(raud_b),
    .sck(sck_b), .lrck(lrck_b), .sdata(sdata_b), .sample(sample_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Offset-binary to signed, scaled by 16.
  function automatic logic [15:0] conv(input logic [11:0] m);
    int v;
    v = (int'(m) - 2048) * 16;
    return 16'(v);
  endfunction

  // Expected {sck, lrck, sdata, sample} n clocks after reset release.
  function automatic logic [3:0] model(input int n, input int div,
                                       input logic [15:0] lw,
                                       input logic [15:0] rw);
    int f, cnt, k;
    logic [15:0] w;
    logic sd, s, l, p;
    f   = n / (2 * div);
    cnt = f % 64;
    k   = cnt % 32;
    w   = (cnt >= 32) ? rw : lw;
    sd  = (k >= 1 && k <= 16) ? w[16 - k] : 1'b0;
    s   = ((n / div) % 2) == 1;
    l   = cnt >= 32;
    p   = (n > 0) && (n % (128 * div) == 0);
    return {s, l, sd, p};
  endfunction

  int          na, nb;
  logic [15:0] mla, mra, mlb, mrb;

  always @(posedge clock) begin
    if (!rst_a) begin
      na = 0; mla = '0; mra = '0;
    end else begin
      na++;
      if (na % 256 == 0) begin
        mla = conv(laud_a); mra = conv(raud_a);
      end
    end
    #1;
    chk("model_a", {28'd0, sck_a, lrck_a, sdata_a, sample_a},
        {28'd0, model(na, 2, mla, mra)});
  end

  always @(posedge clock) begin
    if (!rst_b) begin
      nb = 0; mlb = '0; mrb = '0;
    end else begin
      nb++;
      if (nb % 128 == 0) begin
        mlb = conv(laud_b); mrb = conv(raud_b);
      end
    end
    #1;
    chk("model_b", {28'd0, sck_b, lrck_b, sdata_b, sample_b},
        {28'd0, model(nb, 1, mlb, mrb)});
  end

  // Capture one frame from the clock after a latch up to the next latch.
  task automatic get_frame(input bit b, input int chg_k,
                           input logic [11:0] chg_l,
                           output logic [15:0] lw, output logic [15:0] rw,
                           output int zbits, output int lrerr,
                           output int cyc, output logic smp);
    int f, k;
    logic prev, cur, sd, lr;
    f = 0; lw = '0; rw = '0; zbits = 0; lrerr = 0; cyc = 0; smp = 1'b0;
    prev = b ? sck_b : sck_a;
    while (f < 64 && cyc < 2048) begin
      @(posedge clock); #1;
      cyc++;
      cur = b ? sck_b : sck_a;
      if (prev && !cur) begin
        f++;
        k  = f % 32;
        sd = b ? sdata_b : sdata_a;
        lr = b ? lrck_b : lrck_a;
        if (lr !== ((f % 64) >= 32)) lrerr++;
        if (k >= 1 && k <= 16) begin
          if (f < 32) lw[16 - k] = sd;
          else rw[16 - k] = sd;
        end else if (sd !== 1'b0) zbits++;
        if (f == chg_k) begin
          if (b) laud_b = chg_l;
          else laud_a = chg_l;
        end
        if (f == 64) smp = b ? sample_b : sample_a;
      end
      prev = cur;
    end
    chk("frame_done", f, 64);
  endtask

  task automatic frame_chk(input string nm, input bit b, input int div,
                           input int chg_k, input logic [11:0] chg_l,
                           input logic [15:0] el, input logic [15:0] er);
    logic [15:0] lw, rw;
    int z, lre, cyc;
    logic smp;
    get_frame(b, chg_k, chg_l, lw, rw, z, lre, cyc, smp);
    chk({nm, "_left"}, lw, el);
    chk({nm, "_right"}, rw, er);
    chk({nm, "_padzero"}, z, 0);
    chk({nm, "_lrck"}, lre, 0);
    chk({nm, "_period"}, cyc, 128 * div);
    chk({nm, "_sample"}, smp, 1);
  endtask

  // Count clocks from release to first sample, with sck/sdata stats.
  task automatic to_sample(input bit b, output int cyc, output int rises,
                           output int first_rise, output int ones);
    logic prev, cur, found;
    cyc = 0; rises = 0; first_rise = 0; ones = 0; found = 1'b0; prev = 1'b0;
    while (!found && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
      cur = b ? sck_b : sck_a;
      if (!prev && cur) begin
        rises++;
        if (first_rise == 0) first_rise = cyc;
      end
      if ((b ? sdata_b : sdata_a) !== 1'b0) ones++;
      found = b ? sample_b : sample_a;
      prev = cur;
    end
  endtask

  initial begin
    int cyc, rises, fr, ones;
    n_chk = 0; n_fail = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    laud_a = 12'h800; raud_a = 12'hFFF;
    laud_b = 12'hAAA; raud_b = 12'h555;

    chk("conv_800", conv(12'h800), 16'h0000);
    chk("conv_000", conv(12'h000), 16'h8000);
    chk("conv_fff", conv(12'hFFF), 16'h7FF0);
    chk("conv_123", conv(12'h123), 16'h9230);
    chk("conv_aaa", conv(12'hAAA), 16'h2AA0);
    chk("conv_555", conv(12'h555), 16'hD550);
    chk("model_n2", model(2, 2, 16'h0, 16'h0), 4'b1000);
    chk("model_n4", model(4, 2, 16'h8000, 16'h0), 4'b0010);
    chk("model_n256", model(256, 2, 16'h0, 16'h0), 4'b0001);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_a", {sck_a, lrck_a, sdata_a, sample_a}, 4'b0000);

    @(negedge clock); rst_a = 1'b1;
    to_sample(1'b0, cyc, rises, fr, ones);
    chk("first_sample_a", cyc, 256);
    chk("first_rise_a", fr, 2);
    chk("sck_rises_a", rises, 64);
    chk("first_frame_silent", ones, 0);

    laud_a = 12'h000; raud_a = 12'h123;
    frame_chk("f1", 1'b0, 2, -1, 12'h0, 16'h0000, 16'h7FF0);
    frame_chk("f2", 1'b0, 2, 8, 12'hFFF, 16'h8000, 16'h9230);
    frame_chk("f3", 1'b0, 2, -1, 12'h0, 16'h7FF0, 16'h9230);

    repeat (160) @(posedge clock);
    @(negedge clock); rst_a = 1'b0;
    @(posedge clock); #1;
    chk("midreset_out", {sck_a, lrck_a, sdata_a, sample_a}, 4'b0000);
    repeat (2) @(posedge clock);
    #1;
    chk("midreset_hold", {sck_a, lrck_a, sdata_a, sample_a}, 4'b0000);
    @(negedge clock); rst_a = 1'b1;
    to_sample(1'b0, cyc, rises, fr, ones);
    chk("relatch_a", cyc, 256);
    chk("restart_silent", ones, 0);
    chk("restart_rise", fr, 2);

    @(negedge clock); rst_b = 1'b1;
    to_sample(1'b1, cyc, rises, fr, ones);
    chk("first_sample_b", cyc, 128);
    chk("first_rise_b", fr, 1);
    laud_b = 12'h555; raud_b = 12'hAAA;
    frame_chk("b1", 1'b1, 1, -1, 12'h0, 16'h2AA0, 16'hD550);
    laud_b = 12'hAAA; raud_b = 12'h555;
    frame_chk("b2", 1'b1, 1, -1, 12'h0, 16'hD550, 16'h2AA0);
    laud_b = 12'h555; raud_b = 12'hAAA;
    frame_chk("b3", 1'b1, 1, -1, 12'h0, 16'h2AA0, 16'hD550);

    @(posedge clock); #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s.md
# i2s

Serial audio transmitter downstream of the stereo mixer. Takes the mixer's two 12-bit unsigned channel sums and converts each to 16-bit two's complement. Frames both channels as standard Philips I2S, 32 bit-clocks per channel slot, for an external audio DAC. Generates its own bit clock and word select from the system clock.

## Interface
- DIV, 14: system clocks per bit-clock half period; must be ≥1. Bit clock = clock/(2·DIV); sample rate = clock/(128·DIV).
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- laudio  input  12  left mix, unsigned; sampled only at the frame latch.
- raudio  input  12  right mix, unsigned; sampled only at the frame latch.
- sck  output  1  I2S bit clock.
- lrck  output  1  word select; 0 = left slot, 1 = right slot.
- sdata  output  1  serial data, MSB first.
- sample  output  1  one-clock pulse when laudio/raudio are latched.

## Operation
- Conversion: word = {~in[11], in[10:0], 4'b0000}.
  - 12'h800 → 16'h0000.
  - 12'h000 → 16'h8000.
  - 12'hFFF → 16'h7FF0.
- Divider counter div runs 0..DIV-1. On the clock where div = DIV-1: div wraps to 0 and sck toggles.
- Bit counter cnt is 6 bits. It increments on every sck falling edge, i.e. the clock where sck toggles 1→0, and wraps 63→0.
- All serial outputs (lrck, sdata) update only on sck falling-edge clocks. The DAC samples on the rising edge.
- lrck = cnt[5], registered together with cnt.
- Latch: on the falling-edge clock where cnt wraps 63→0:
  - both converted words load into holding registers lword and rword;
  - sample pulses high for exactly that clock.
- Inputs at any other time are ignored. Both channels always come from the same clock.
- sdata at slot position k = cnt[4:0] (1-bit I2S delay after the lrck edge):
  - k = 1..16 → word[16-k], where word is lword when cnt[5]=0 and rword when cnt[5]=1;
  - k = 0 and k = 17..31 → 0.

## Timing
- Reset values, applied on the first rising edge with reset=0:
  - div=0, sck=0, cnt=0, lrck=0, sdata=0, sample=0, lword=rword=16'h0000.
- While reset=0 all outputs hold these values.
- After reset release:
  - sck first rises after DIV clocks and first falls after 2·DIV clocks (cnt→1).
  - sck period is exactly 2·DIV clocks, 50% duty.
- The first frame transmits 16'h0000 on both slots, which is midscale silence.
- The first latch (sample pulse) occurs 128·DIV clocks after reset release, then every 128·DIV clocks.
- Latch-to-output latency:
  - left MSB appears one sck period after the latch (cnt=1);
  - right MSB appears at cnt=33.
- lrck and sdata change on the same clock as the sck 1→0 transition, never on rise.
- Reset mid-frame: output returns immediately (next rising edge) to reset values. The partial frame is discarded and the frame restarts from cnt=0 with zero words.
- Input changing on the latch clock: the value present on that clock edge is captured.
- DIV=1: sck toggles every clock and all rules above still hold.

## Structure
- Single module. The divider is small enough to stay inline; no sub-module.
- Shared audio package constants:
  - SLOT_BITS = 32;
  - FRAME_BITS = 64;
  - WORD_BITS = 16;
  - MIX_BITS = 12.
- Divider width is $clog2(DIV), minimum 1.
- Holding registers are separate from the serialiser: do not shift the holding registers in place. Use index selection or a separate shift register reloaded at cnt=0/32.

## Test plan
- Reset release, DIV=2: sck period 4 clocks; first sample pulse at clock 256 after release; sdata stays 0 for the entire first frame.
- laudio=12'h800, raudio=12'hFFF held: after the first latch, left slot bits 1..16 = 16'h0000 and right slot = 16'h7FF0 MSB-first; bits 17..31 of each slot are 0.
- laudio=12'h000, raudio=12'h123: left = 16'h8000; right = 16'h9230.
- laudio changes from 12'h000 to 12'hFFF mid-left-slot (cnt=8): the current frame continues 16'h8000; the next frame carries 16'h7FF0.
- Assert reset at cnt=40 for 3 clocks: sck, lrck, sdata and sample are 0 from the next edge; the frame restarts at cnt=0 and the next latch is 128·DIV clocks after release.
- DIV=1 with alternating inputs 12'hAAA/12'h555 each frame:
  - sample asserts one clock every 128 clocks;
  - lrck toggles at cnt 0/32;
  - serial words match 16'h2AA0 and 16'hD550.
